csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
// - M-mode CSR file; parametrised successor of the trap-only CSR unit. Adds Zicsr access
//   (CSRRW/CSRRS/CSRRC), mie/mip interrupt gating, mscratch/mtval, vectored mtvec, and
//   64-bit mcycle/minstret. Sits beside decoder/execute.
// - Decoder drives the CSR port and trap/mret strobes. PC module consumes trap_target and
//   mepc_out. The interrupt controller consumes irq_take.
// PARAMETERS
// - MTVEC_RESET  32'h0000_0100  mtvec reset value; bits[1:0] give reset mode
// - HART_ID      0              value returned by mhartid
// - VECTORED_EN  1              1: mtvec mode 1 is legal. 0: mode bits hardwired 00
// - COUNTER_EN   1              1: mcycle/minstret implemented. 0: those addresses are illegal
// PORTS
// - clk            in   1   clock, rising edge
// - rst            in   1   synchronous reset, active-low (rst==0 resets on the clk edge)
// - csr_req        in   1   CSR instruction valid this cycle
// - csr_op         in   2   01=RW, 10=RS (set), 11=RC (clear), 00=no-op
// - csr_addr       in   12  CSR address
// - csr_wdata      in   32  rs1/uimm operand
// - csr_rdata      out  32  old value of csr_addr; combinational
// - csr_illegal    out  1   combinational; access is illegal, no state change
// - trap_enter     in   1   exception or interrupt taken
// - trap_cause     in   32  mcause value; bit31=interrupt
// - trap_pc        in   32  pc to save in mepc
// - trap_tval      in   32  value for mtval
// - mret_exec      in   1   MRET retiring
// - instr_retire   in   1   one instruction retired this cycle
// - irq_ext/irq_timer/irq_sw  in  1 each  level-sensitive MEIP/MTIP/MSIP sources
// - trap_target    out  32  next-pc on trap; combinational from mtvec and trap_cause
// - mepc_out       out  32  current mepc
// - irq_take       out  1   mstatus.MIE & |(mip & mie)
// BEHAVIOUR
// - Reset values:
//   - mtvec=MTVEC_RESET (mode masked if !VECTORED_EN)
//   - mstatus=32'h0000_1800: MPP=11 hardwired, MIE=MPIE=0
//   - mie, mscratch, mepc, mcause, mtval, mcycle, minstret all 0
//   - Outputs follow from these: csr_rdata depends on the address, irq_take=0, mepc_out=0
// - Map:
//   - 300 mstatus (only bits 3 and 7 writable)
//   - 304 mie (bits 3, 7, 11 writable)
//   - 305 mtvec (mode bit1 forced 0)
//   - 340 mscratch
//   - 341 mepc (bits[1:0] forced 0)
//   - 342 mcause
//   - 343 mtval
//   - 344 mip (read-only, {irq_ext,irq_timer,irq_sw} at bits 11/7/3)
//   - B00/B80 mcycle lo/hi; B02/B82 minstret lo/hi
//   - F14 mhartid (read-only)
// - Write value: RW=wdata; RS=old|wdata; RC=old&~wdata. Commits on the next clk edge.
//   csr_rdata always returns the pre-write value.
// - csr_illegal=1 in either case below; state is untouched:
//   - unimplemented address (includes counters when COUNTER_EN=0)
//   - read-only address with op==RW, or op RS/RC with wdata!=0
// - Read-only address with RS/RC and wdata==0: legal read, no write.
// - Trap entry:
//   - mepc<=trap_pc&~3; mcause<=trap_cause; mtval<=trap_tval
//   - MPIE<=MIE; MIE<=0
// - trap_target:
//   - mode 0, or exception: {mtvec[31:2],2'b00}
//   - mode 1 and trap_cause[31]=1: base + 4*trap_cause[4:0], 32-bit wrap
// - MRET: MIE<=MPIE; MPIE<=1.
// - Priority within one cycle: trap_enter > mret_exec > CSR write.
//   - Lower-priority writes to overlapping state are dropped.
//   - A CSR write to an unrelated CSR still commits (e.g. trap + mscratch write).
// - Counters:
//   - mcycle+=1 every cycle out of reset; minstret+=1 when instr_retire
//   - 64-bit, wrap FFFF_FFFF_FFFF_FFFF->0
//   - A CSR write to either half replaces that half; the increment is suppressed for that counter in that cycle
//   - The lo->hi carry uses the pre-write value
// - Reset asserted mid-operation overrides all strobes that cycle; strobes are ignored while rst==0.
// TESTING
// - Reset:
//   - rst=0 for 2 clk, then read 305/300 -> 0000_0100 / 0000_1800
//   - read mcycle lo after 5 idle cycles -> 5
// - CSR ops:
//   - RW 340 wdata=A5A5_0000 -> csr_rdata=0
//   - RS 340 wdata=0000_00FF -> rdata=A5A5_0000
//   - RC 340 wdata=A500_000F -> readback 00A5_00F0
// - Vectored interrupt:
//   - mtvec=0000_2001, MIE=1, mie=0x800, irq_ext=1 -> irq_take=1
//   - trap_enter cause=8000_000B pc=0000_0404 -> trap_target=0000_202C, mepc=0000_0404
//   - MIE=0, MPIE=1
// - Exception then MRET:
//   - cause=0000_000B (MIE was 1) -> trap_target=0000_2000
//   - mret_exec -> MIE=1, MPIE=1
//   - with trap_enter+mret same cycle: trap wins
// - Illegal:
//   - RW to F14 -> csr_illegal=1, mhartid unchanged
//   - RS to 344 wdata=0 -> legal, rdata=mip
//   - read 7C0 -> csr_illegal=1
// - Counter:
//   - write B00=FFFF_FFFF, then idle 1 cycle -> mcycle hi=1, lo=0
//   - instr_retire on the write cycle to B02 -> written value kept, no increment

Source files
------------

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
//  Module   : csr_file
//  Purpose  : M-mode CSR file with Zicsr access, interrupt gating, vectored
//             mtvec and 64-bit mcycle/minstret counters.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter bit          VECTORED_EN = 1'b1,
    parameter bit          COUNTER_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        trap_enter,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_exec,
    input  logic        instr_retire,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_sw,
    output logic [31:0] trap_target,
    output logic [31:0] mepc_out,
    output logic        irq_take
);

    localparam logic [1:0]  c_op_rw       = 2'b01;
    localparam logic [1:0]  c_op_rs       = 2'b10;
    localparam logic [11:0] c_addr_status = 12'h300;
    localparam logic [11:0] c_addr_mie    = 12'h304;
    localparam logic [11:0] c_addr_mtvec  = 12'h305;
    localparam logic [11:0] c_addr_scr    = 12'h340;
    localparam logic [11:0] c_addr_mepc   = 12'h341;
    localparam logic [11:0] c_addr_mcause = 12'h342;
    localparam logic [11:0] c_addr_mtval  = 12'h343;
    localparam logic [11:0] c_addr_mip    = 12'h344;
    localparam logic [11:0] c_addr_cyc_lo = 12'hB00;
    localparam logic [11:0] c_addr_ins_lo = 12'hB02;
    localparam logic [11:0] c_addr_cyc_hi = 12'hB80;
    localparam logic [11:0] c_addr_ins_hi = 12'hB82;
    localparam logic [11:0] c_addr_hartid = 12'hF14;
    localparam logic [31:0] c_mtvec_mask  = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
    localparam logic [31:0] c_mie_mask    = 32'h0000_0888;

    logic        r_status_mie;
    logic        r_status_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [31:0] w_mstatus;
    logic [31:0] w_mip;
    logic [31:0] w_old;
    logic [31:0] w_wval;
    logic [31:0] w_mtvec_base;
    logic        w_addr_ok;
    logic        w_addr_ro;
    logic        w_active;
    logic        w_setclr_zero;
    logic        w_illegal;
    logic        w_write;

    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_status_mpie, 3'd0, r_status_mie, 3'd0};
    assign w_mip     = {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_sw, 3'd0};

    always_comb begin
        w_old     = 32'd0;
        w_addr_ok = 1'b1;
        w_addr_ro = 1'b0;
        case (csr_addr)
            c_addr_status: w_old = w_mstatus;
            c_addr_mie:    w_old = r_mie;
            c_addr_mtvec:  w_old = r_mtvec;
            c_addr_scr:    w_old = r_mscratch;
            c_addr_mepc:   w_old = r_mepc;
            c_addr_mcause: w_old = r_mcause;
            c_addr_mtval:  w_old = r_mtval;
            c_addr_mip:    begin w_old = w_mip;   w_addr_ro = 1'b1; end
            c_addr_hartid: begin w_old = HART_ID; w_addr_ro = 1'b1; end
            c_addr_cyc_lo: begin w_old = w_mcycle[31:0];    w_addr_ok = COUNTER_EN; end
            c_addr_cyc_hi: begin w_old = w_mcycle[63:32];   w_addr_ok = COUNTER_EN; end
            c_addr_ins_lo: begin w_old = w_minstret[31:0];  w_addr_ok = COUNTER_EN; end
            c_addr_ins_hi: begin w_old = w_minstret[63:32]; w_addr_ok = COUNTER_EN; end
            default:       w_addr_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_wval = csr_wdata;
        if (csr_op == c_op_rs)      w_wval = w_old | csr_wdata;
        else if (csr_op != c_op_rw) w_wval = w_old & ~csr_wdata;
    end

    // Set/clear with a zero operand is a pure read: no write, no counter stall.
    assign w_active      = csr_req && (csr_op != 2'b00);
    assign w_setclr_zero = (csr_op != c_op_rw) && (csr_wdata == 32'd0);
    assign w_illegal     = w_active && (!w_addr_ok || (w_addr_ro && !w_setclr_zero));
    assign w_write       = w_active && !w_illegal && !w_setclr_zero;

    assign csr_rdata   = w_old;
    assign csr_illegal = w_illegal;
    assign mepc_out    = r_mepc;
    assign irq_take    = r_status_mie && (|(w_mip & r_mie));

    assign w_mtvec_base = {r_mtvec[31:2], 2'b00};
    assign trap_target  = (r_mtvec[0] && trap_cause[31])
                        ? w_mtvec_base + {25'd0, trap_cause[4:0], 2'b00}
                        : w_mtvec_base;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_status_mie  <= 1'b0;
            r_status_mpie <= 1'b0;
            r_mie         <= 32'd0;
            r_mtvec       <= MTVEC_RESET & c_mtvec_mask;
            r_mscratch    <= 32'd0;
            r_mepc        <= 32'd0;
            r_mcause      <= 32'd0;
            r_mtval       <= 32'd0;
        end else begin
            if (trap_enter) begin
                r_status_mpie <= r_status_mie;
                r_status_mie  <= 1'b0;
                r_mepc        <= trap_pc & ~32'd3;
                r_mcause      <= trap_cause;
                r_mtval       <= trap_tval;
            end else if (mret_exec) begin
                r_status_mie  <= r_status_mpie;
                r_status_mpie <= 1'b1;
            end else if (w_write && csr_addr == c_addr_status) begin
                r_status_mie  <= w_wval[3];
                r_status_mpie <= w_wval[7];
            end

            // Trap-owned registers lose a same-cycle CSR write.
            if (w_write && !trap_enter) begin
                case (csr_addr)
                    c_addr_mepc:   r_mepc   <= w_wval & ~32'd3;
                    c_addr_mcause: r_mcause <= w_wval;
                    c_addr_mtval:  r_mtval  <= w_wval;
                    default: ;
                endcase
            end

            if (w_write) begin
                case (csr_addr)
                    c_addr_mie:   r_mie      <= w_wval & c_mie_mask;
                    c_addr_mtvec: r_mtvec    <= w_wval & c_mtvec_mask;
                    c_addr_scr:   r_mscratch <= w_wval;
                    default: ;
                endcase
            end
        end
    end

    generate
        if (COUNTER_EN) begin : g_counters
            logic [63:0] r_mcycle;
            logic [63:0] r_minstret;

            // A write to either half replaces it and stalls that counter for the cycle.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_mcycle   <= 64'd0;
                    r_minstret <= 64'd0;
                end else begin
                    if (w_write && csr_addr == c_addr_cyc_lo)
                        r_mcycle <= {r_mcycle[63:32], w_wval};
                    else if (w_write && csr_addr == c_addr_cyc_hi)
                        r_mcycle <= {w_wval, r_mcycle[31:0]};
                    else
                        r_mcycle <= r_mcycle + 64'd1;

                    if (w_write && csr_addr == c_addr_ins_lo)
                        r_minstret <= {r_minstret[63:32], w_wval};
                    else if (w_write && csr_addr == c_addr_ins_hi)
                        r_minstret <= {w_wval, r_minstret[31:0]};
                    else if (instr_retire)
                        r_minstret <= r_minstret + 64'd1;
                end
            end

            assign w_mcycle   = r_mcycle;
            assign w_minstret = r_minstret;
        end else begin : g_no_counters
            assign w_mcycle   = 64'd0;
            assign w_minstret = 64'd0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_file
//  Purpose  : Directed self-checking bench for csr_file.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_req;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_enter;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_exec;
    logic        instr_retire;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_sw;
    logic [31:0] trap_target;
    logic [31:0] mepc_out;
    logic        irq_take;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] c_rw = 2'b01;
    localparam logic [1:0] c_rs = 2'b10;
    localparam logic [1:0] c_rc = 2'b11;

    always #5 clk = ~clk;

    csr_file dut (
        .clk          (clk),
        .rst          (rst),
        .csr_req      (csr_req),
        .csr_op       (csr_op),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .trap_enter   (trap_enter),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_tval    (trap_tval),
        .mret_exec    (mret_exec),
        .instr_retire (instr_retire),
        .irq_ext      (irq_ext),
        .irq_timer    (irq_timer),
        .irq_sw       (irq_sw),
        .trap_target  (trap_target),
        .mepc_out     (mepc_out),
        .irq_take     (irq_take)
    );

    // Inputs change on the falling edge; at most three peeks follow, staying clear of the rising edge.
    task automatic clear_strobes();
        csr_req = 1'b0; csr_op = 2'b00; csr_addr = 12'h000; csr_wdata = 32'd0;
        trap_enter = 1'b0; trap_cause = 32'd0; trap_pc = 32'd0; trap_tval = 32'd0;
        mret_exec = 1'b0; instr_retire = 1'b0;
    endtask

    task automatic drive_csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        @(negedge clk);
        clear_strobes();
        csr_req = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
        #1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        clear_strobes();
        #1;
    endtask

    task automatic peek(input logic [11:0] addr);
        csr_req = 1'b0; csr_op = 2'b00; csr_addr = addr;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        peek(12'h305);
        n_tests++; if (csr_rdata !== 32'h0000_0100) begin n_fail++; $display("FAIL reset_mtvec: got %h want %h", csr_rdata, 32'h0000_0100); end
        peek(12'h300);
        n_tests++; if (csr_rdata !== 32'h0000_1800) begin n_fail++; $display("FAIL reset_mstatus: got %h want %h", csr_rdata, 32'h0000_1800); end
        n_tests++; if (irq_take !== 1'b0 || mepc_out !== 32'd0) begin n_fail++; $display("FAIL reset_outputs: irq_take=%b mepc=%h want 0/0", irq_take, mepc_out); end
        peek(12'hB00);
        n_tests++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_mcycle_held: got %h want 0", csr_rdata); end
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        peek(12'hB00);
        n_tests++; if (csr_rdata !== 32'd5) begin n_fail++; $display("FAIL mcycle_after_5: got %h want 5", csr_rdata); end
    endtask

    task automatic test_csr_ops();
        drive_csr(c_rw, 12'h340, 32'hA5A5_0000);
        n_tests++; if (csr_rdata !== 32'd0 || csr_illegal !== 1'b0) begin n_fail++; $display("FAIL rw_mscratch: rdata=%h ill=%b want 0/0", csr_rdata, csr_illegal); end
        drive_csr(c_rs, 12'h340, 32'h0000_00FF);
        n_tests++; if (csr_rdata !== 32'hA5A5_0000) begin n_fail++; $display("FAIL rs_mscratch: got %h want A5A50000", csr_rdata); end
        drive_csr(c_rc, 12'h340, 32'hA500_000F);
        n_tests++; if (csr_rdata !== 32'hA5A5_00FF) begin n_fail++; $display("FAIL rc_mscratch_old: got %h want A5A500FF", csr_rdata); end
        go_idle();
        peek(12'h340);
        n_tests++; if (csr_rdata !== 32'h00A5_00F0) begin n_fail++; $display("FAIL rc_mscratch_new: got %h want 00A500F0", csr_rdata); end

        drive_csr(c_rw, 12'h304, 32'hFFFF_FFFF);
        go_idle();
        peek(12'h304);
        n_tests++; if (csr_rdata !== 32'h0000_0888) begin n_fail++; $display("FAIL mie_mask: got %h want 00000888", csr_rdata); end

        drive_csr(c_rw, 12'h300, 32'hFFFF_FFFF);
        go_idle();
        peek(12'h300);
        n_tests++; if (csr_rdata !== 32'h0000_1888) begin n_fail++; $display("FAIL mstatus_mask: got %h want 00001888", csr_rdata); end
        drive_csr(c_rc, 12'h300, 32'hFFFF_FFFF);
        go_idle();
        peek(12'h300);
        n_tests++; if (csr_rdata !== 32'h0000_1800) begin n_fail++; $display("FAIL mstatus_clear: got %h want 00001800", csr_rdata); end

        drive_csr(c_rw, 12'h341, 32'h0000_1237);
        go_idle();
        n_tests++; if (mepc_out !== 32'h0000_1234) begin n_fail++; $display("FAIL mepc_align: got %h want 00001234", mepc_out); end
    endtask

    task automatic test_vectored_irq();
        drive_csr(c_rw, 12'h305, 32'h0000_2003);
        go_idle();
        peek(12'h305);
        n_tests++; if (csr_rdata !== 32'h0000_2001) begin n_fail++; $display("FAIL mtvec_bit1: got %h want 00002001", csr_rdata); end

        drive_csr(c_rw, 12'h304, 32'h0000_0800);
        go_idle();
        irq_ext = 1'b1;
        #1;
        n_tests++; if (irq_take !== 1'b0) begin n_fail++; $display("FAIL irq_gated_by_mie: got %b want 0", irq_take); end
        peek(12'h344);
        n_tests++; if (csr_rdata !== 32'h0000_0800) begin n_fail++; $display("FAIL mip_read: got %h want 00000800", csr_rdata); end

        drive_csr(c_rs, 12'h300, 32'h0000_0008);
        go_idle();
        n_tests++; if (irq_take !== 1'b1) begin n_fail++; $display("FAIL irq_take: got %b want 1", irq_take); end

        @(negedge clk);
        clear_strobes();
        trap_enter = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h0000_0404; trap_tval = 32'hDEAD_BEEF;
        #1;
        n_tests++; if (trap_target !== 32'h0000_202C) begin n_fail++; $display("FAIL vec_target: got %h want 0000202C", trap_target); end
        go_idle();
        n_tests++; if (mepc_out !== 32'h0000_0404 || irq_take !== 1'b0) begin n_fail++; $display("FAIL irq_trap_state: mepc=%h take=%b want 00000404/0", mepc_out, irq_take); end
        peek(12'h300);
        n_tests++; if (csr_rdata !== 32'h0000_1880) begin n_fail++; $display("FAIL irq_trap_mstatus: got %h want 00001880", csr_rdata); end
        peek(12'h342);
        n_tests++; if (csr_rdata !== 32'h8000_000B) begin n_fail++; $display("FAIL irq_trap_mcause: got %h want 8000000B", csr_rdata); end
        peek(12'h343);
        n_tests++; if (csr_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL irq_trap_mtval: got %h want DEADBEEF", csr_rdata); end
        irq_ext = 1'b0;
    endtask

    task automatic test_exception_mret();
        drive_csr(c_rs, 12'h300, 32'h0000_0008);
        @(negedge clk);
        clear_strobes();
        trap_enter = 1'b1; trap_cause = 32'h0000_000B; trap_pc = 32'h0000_0407;
        #1;
        n_tests++; if (trap_target !== 32'h0000_2000) begin n_fail++; $display("FAIL exc_target: got %h want 00002000", trap_target); end
        go_idle();
        n_tests++; if (mepc_out !== 32'h0000_0404) begin n_fail++; $display("FAIL exc_mepc: got %h want 00000404", mepc_out); end
        peek(12'h300);
        n_tests++; if (csr_rdata !== 32'h0000_1880) begin n_fail++; $display("FAIL exc_mstatus: got %h want 00001880", csr_rdata); end

        @(negedge clk);
        clear_strobes();
        mret_exec = 1'b1;
        go_idle();
        peek(12'h300);
        n_tests++; if (csr_rdata !== 32'h0000_1888) begin n_fail++; $display("FAIL mret_mstatus: got %h want 00001888", csr_rdata); end

        // Trap, MRET and an unrelated CSR write all in one cycle.
        @(negedge clk);
        clear_strobes();
        trap_enter = 1'b1; trap_cause = 32'h0000_0002; trap_pc = 32'h0000_0808;
        mret_exec = 1'b1;
        csr_req = 1'b1; csr_op = c_rw; csr_addr = 12'h340; csr_wdata = 32'h1111_2222;
        go_idle();
        n_tests++; if (mepc_out !== 32'h0000_0808) begin n_fail++; $display("FAIL trap_mret_mepc: got %h want 00000808", mepc_out); end
        peek(12'h300);
        n_tests++; if (csr_rdata !== 32'h0000_1880) begin n_fail++; $display("FAIL trap_beats_mret: got %h want 00001880", csr_rdata); end
        peek(12'h340);
        n_tests++; if (csr_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL trap_side_write: got %h want 11112222", csr_rdata); end
        peek(12'h342);
        n_tests++; if (csr_rdata !== 32'h0000_0002) begin n_fail++; $display("FAIL trap_mret_mcause: got %h want 00000002", csr_rdata); end

        // MRET wins over a CSR write to mstatus.
        drive_csr(c_rw, 12'h300, 32'h0000_0000);
        mret_exec = 1'b1;
        go_idle();
        peek(12'h300);
        n_tests++; if (csr_rdata !== 32'h0000_1888) begin n_fail++; $display("FAIL mret_beats_csr: got %h want 00001888", csr_rdata); end
    endtask

    task automatic test_illegal();
        drive_csr(c_rw, 12'hF14, 32'h0000_0005);
        n_tests++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'd0) begin n_fail++; $display("FAIL rw_hartid: ill=%b rdata=%h want 1/0", csr_illegal, csr_rdata); end
        go_idle();
        peek(12'hF14);
        n_tests++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL hartid_kept: got %h want 0", csr_rdata); end
        irq_timer = 1'b1; irq_sw = 1'b1;
        drive_csr(c_rs, 12'h344, 32'd0);
        n_tests++; if (csr_illegal !== 1'b0 || csr_rdata !== 32'h0000_0088) begin n_fail++; $display("FAIL rs0_mip: ill=%b rdata=%h want 0/00000088", csr_illegal, csr_rdata); end
        drive_csr(c_rs, 12'h344, 32'd1);
        n_tests++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL rs1_mip: ill=%b want 1", csr_illegal); end
        drive_csr(c_rs, 12'h7C0, 32'd0);
        n_tests++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL unimpl_7c0: ill=%b want 1", csr_illegal); end
        go_idle();
        irq_timer = 1'b0; irq_sw = 1'b0;
    endtask

    task automatic test_counters();
        drive_csr(c_rw, 12'hB80, 32'd0);
        drive_csr(c_rw, 12'hB00, 32'hFFFF_FFFF);
        go_idle();
        peek(12'hB00);
        n_tests++; if (csr_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycle_written: got %h want FFFFFFFF", csr_rdata); end
        @(posedge clk);
        #1;
        peek(12'hB00);
        n_tests++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL mcycle_lo_carry: got %h want 0", csr_rdata); end
        peek(12'hB80);
        n_tests++; if (csr_rdata !== 32'd1) begin n_fail++; $display("FAIL mcycle_hi_carry: got %h want 1", csr_rdata); end

        drive_csr(c_rw, 12'hB82, 32'd0);
        drive_csr(c_rw, 12'hB02, 32'd0);
        @(negedge clk);
        clear_strobes();
        instr_retire = 1'b1;
        go_idle();
        peek(12'hB02);
        n_tests++; if (csr_rdata !== 32'd1) begin n_fail++; $display("FAIL minstret_inc: got %h want 1", csr_rdata); end
        drive_csr(c_rw, 12'hB02, 32'h0000_1000);
        instr_retire = 1'b1;
        go_idle();
        peek(12'hB02);
        n_tests++; if (csr_rdata !== 32'h0000_1000) begin n_fail++; $display("FAIL minstret_write_wins: got %h want 00001000", csr_rdata); end
        @(negedge clk);
        clear_strobes();
        instr_retire = 1'b1;
        go_idle();
        peek(12'hB02);
        n_tests++; if (csr_rdata !== 32'h0000_1001) begin n_fail++; $display("FAIL minstret_resume: got %h want 00001001", csr_rdata); end

        drive_csr(c_rw, 12'hB02, 32'hFFFF_FFFF);
        drive_csr(c_rw, 12'hB82, 32'hFFFF_FFFF);
        @(negedge clk);
        clear_strobes();
        instr_retire = 1'b1;
        go_idle();
        peek(12'hB02);
        n_tests++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL minstret_wrap_lo: got %h want 0", csr_rdata); end
        peek(12'hB82);
        n_tests++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL minstret_wrap_hi: got %h want 0", csr_rdata); end
    endtask

    task automatic test_reset_midop();
        drive_csr(c_rw, 12'h340, 32'hCAFE_0000);
        trap_enter = 1'b1; trap_cause = 32'h0000_0005; trap_pc = 32'h0000_0F00;
        rst = 1'b0;
        go_idle();
        n_tests++; if (mepc_out !== 32'd0) begin n_fail++; $display("FAIL midrst_mepc: got %h want 0", mepc_out); end
        peek(12'h340);
        n_tests++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL midrst_mscratch: got %h want 0", csr_rdata); end
        peek(12'h300);
        n_tests++; if (csr_rdata !== 32'h0000_1800) begin n_fail++; $display("FAIL midrst_mstatus: got %h want 00001800", csr_rdata); end
        peek(12'hB00);
        n_tests++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL midrst_mcycle: got %h want 0", csr_rdata); end
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_strobes();
        irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0;
        test_reset();
        test_csr_ops();
        test_vectored_irq();
        test_exception_mret();
        test_illegal();
        test_counters();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
